isa_io_cycle_sequencer: RTL

- Upstream sequencer for the ISA bus interface stage on the CT2960 riser.
- Accepts one HPS I/O request at a time through a req/busy/done handshake and drives the interface stage's address_load, data_load, iow and ior lines with programmable setup, strobe and hold timing.
- On reads, captures the data the interface stage returns.

---
 rtl/isa_io_cycle_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/isa_io_cycle_sequencer.sv
// ISA I/O cycle sequencer: drives address/data load pulses and the iow/ior strobe with
// programmable setup/strobe/hold timing. Define IOCHRDY_EN for iochrdy wait states with timeout.
module isa_io_cycle_sequencer #(
  parameter int SETUP_CYC   = 4,
  parameter int STROBE_CYC  = 12,
  parameter int HOLD_CYC    = 2,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic [15:0] addr_in,
  input  logic [15:0] wdata_in,
  input  logic [15:0] data_HPS_in,
`ifdef IOCHRDY_EN
  input  logic        iochrdy,
  output logic        timeout,
`endif
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata_out,
  output logic [15:0] address_HPS_out,
  output logic [15:0] data_HPS_out,
  output logic        address_load,
  output logic        data_load,
  output logic        iow,
  output logic        ior
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1 || TIMEOUT_CYC < 1 ||
      SETUP_CYC > (2**CNT_W) - 1 || STROBE_CYC > (2**CNT_W) - 1 ||
      HOLD_CYC > (2**CNT_W) - 1) begin : g_cfg_err
    $error("isa_io_cycle_sequencer: illegal timing parameters");
  end

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             rw_r, rw_s;
  logic             accept_s;
  logic             strobe_exit_s;
`ifdef IOCHRDY_EN
  localparam int EXT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [EXT_W-1:0] EXT_ZERO = {EXT_W{1'b0}};
  localparam logic [EXT_W-1:0] EXT_ONE  = EXT_W'(1);
  localparam logic [EXT_W-1:0] EXT_MAX  = EXT_W'(TIMEOUT_CYC);
  logic [EXT_W-1:0] ext_r, ext_s;
  logic             timeout_s;
`endif

  // Next-state and phase-counter logic; the counter reloads on every state entry.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    rw_s          = rw_r;
    accept_s      = 1'b0;
    strobe_exit_s = 1'b0;
`ifdef IOCHRDY_EN
    ext_s         = ext_r;
    timeout_s     = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          accept_s = 1'b1;
          rw_s     = rw;
          state_s  = ST_LOAD;
          cnt_s    = CNT_ZERO;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_s = ST_SETUP;
        cnt_s   = CNT_W'(SETUP_CYC - 1);
      end
      ST_SETUP: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_STROBE;
          cnt_s   = CNT_W'(STROBE_CYC - 1);
`ifdef IOCHRDY_EN
          ext_s   = EXT_ZERO;
`endif
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      ST_STROBE: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_s = cnt_r - CNT_ONE;
        end else begin
`ifdef IOCHRDY_EN
          // Wait states are only inserted once the programmed strobe time has elapsed.
          if (iochrdy) begin
            strobe_exit_s = 1'b1;
          end else if (ext_r == EXT_MAX) begin
            strobe_exit_s = 1'b1;
            timeout_s     = 1'b1;
          end else begin
            ext_s         = ext_r + EXT_ONE;
          end
`else
          strobe_exit_s = 1'b1;
`endif
        end
        if (strobe_exit_s) begin
          state_s = ST_HOLD;
          cnt_s   = CNT_W'(HOLD_CYC - 1);
        end else begin
          state_s = ST_STROBE;
        end
      end
      ST_HOLD: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_DONE;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State register and registered outputs, decoded from the upcoming state so they align with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= ST_IDLE;
      cnt_r           <= CNT_ZERO;
      rw_r            <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      address_load    <= 1'b0;
      data_load       <= 1'b0;
      iow             <= 1'b1;
      ior             <= 1'b1;
      rdata_out       <= 16'h0000;
      address_HPS_out <= 16'h0000;
      data_HPS_out    <= 16'h0000;
`ifdef IOCHRDY_EN
      ext_r           <= EXT_ZERO;
      timeout         <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      rw_r         <= rw_s;
      busy         <= (state_s != ST_IDLE);
      done         <= (state_s == ST_DONE);
      address_load <= (state_s == ST_LOAD);
      data_load    <= (state_s == ST_LOAD) && rw_s;
      iow          <= !((state_s == ST_STROBE) && rw_s);
      ior          <= !((state_s == ST_STROBE) && !rw_s);
      if (accept_s) begin
        address_HPS_out <= addr_in;
        data_HPS_out    <= wdata_in;
      end
      if (strobe_exit_s && !rw_r) begin
        rdata_out <= data_HPS_in;
      end
`ifdef IOCHRDY_EN
      ext_r <= ext_s;
      if (timeout_s) begin
        timeout <= 1'b1;
      end
`endif
    end
  end

endmodule
